// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU encodings, sequencer states and the decoded control bundle
package cpu_pkg;
  localparam int OPW = 8;
  localparam int ALUOPW = 3;
  localparam logic [OPW-1:0] OP_LOADI = 8'h00;
  localparam logic [OPW-1:0] OP_MOV   = 8'h01;
  localparam logic [OPW-1:0] OP_ADD   = 8'h02;
  localparam logic [OPW-1:0] OP_SUB   = 8'h03;
  localparam logic [OPW-1:0] OP_AND   = 8'h04;
  localparam logic [OPW-1:0] OP_OR    = 8'h05;
  localparam logic [OPW-1:0] OP_J     = 8'h06;
  localparam logic [OPW-1:0] OP_BEQ   = 8'h07;
  localparam logic [OPW-1:0] OP_LWD   = 8'h08;
  localparam logic [OPW-1:0] OP_LWI   = 8'h09;
  localparam logic [OPW-1:0] OP_SWD   = 8'h0A;
  localparam logic [OPW-1:0] OP_SWI   = 8'h0B;
  localparam logic [ALUOPW-1:0] ALU_FWD = 3'b000;
  localparam logic [ALUOPW-1:0] ALU_ADD = 3'b001;
  localparam logic [ALUOPW-1:0] ALU_AND = 3'b010;
  localparam logic [ALUOPW-1:0] ALU_OR  = 3'b011;
  typedef enum logic [1:0] {S_EXEC, S_MEM, S_WB} state_t;
  typedef struct packed {
    logic              mux_im;
    logic              mux_2c;
    logic [ALUOPW-1:0] aluop;
    logic              we;
    logic              jump;
    logic              branch;
    logic              mem;
    logic              load;
    logic              illegal;
  } ctrl_t;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational opcode -> control bundle
//   opcode : in  [OPW-1:0] instruction opcode field
//   ctrl   : out ctrl_t    decoded control bundle
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl
);
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_LOADI: ctrl.we = 1'b1;
      OP_MOV:   begin ctrl.mux_im = 1'b1; ctrl.we = 1'b1; end
      OP_ADD:   begin ctrl.mux_im = 1'b1; ctrl.aluop = ALU_ADD; ctrl.we = 1'b1; end
      OP_SUB:   begin ctrl.mux_im = 1'b1; ctrl.mux_2c = 1'b1; ctrl.aluop = ALU_ADD; ctrl.we = 1'b1; end
      OP_AND:   begin ctrl.mux_im = 1'b1; ctrl.aluop = ALU_AND; ctrl.we = 1'b1; end
      OP_OR:    begin ctrl.mux_im = 1'b1; ctrl.aluop = ALU_OR; ctrl.we = 1'b1; end
      OP_J:     ctrl.jump = 1'b1;
      OP_BEQ:   begin ctrl.mux_im = 1'b1; ctrl.mux_2c = 1'b1; ctrl.aluop = ALU_ADD; ctrl.branch = 1'b1; end
      OP_LWD:   begin ctrl.mux_im = 1'b1; ctrl.mem = 1'b1; ctrl.load = 1'b1; end
      OP_LWI:   begin ctrl.mem = 1'b1; ctrl.load = 1'b1; end
      OP_SWD:   begin ctrl.mux_im = 1'b1; ctrl.mem = 1'b1; end
      OP_SWI:   ctrl.mem = 1'b1;
      default:  ctrl.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle CPU control unit sequencing decode, cache access and load writeback
//   CLK, RESET (async active-low), INSTRUCTION, I_BUSYWAIT (icache stall), BUSYWAIT (dcache stall)
//   MUX_IM, MUX_2C, ALUOP, WRITEENABLE, MUX_MEM, READ, WRITE, JUMP, BRANCH, PC_EN, ILLEGAL
module control_sequencer
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  input  logic              I_BUSYWAIT,
  input  logic              BUSYWAIT,
  output logic              MUX_IM,
  output logic              MUX_2C,
  output logic [ALUOPW-1:0] ALUOP,
  output logic              WRITEENABLE,
  output logic              MUX_MEM,
  output logic              READ,
  output logic              WRITE,
  output logic              JUMP,
  output logic              BRANCH,
  output logic              PC_EN,
  output logic              ILLEGAL
);
  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  ctrl_t          dec, held;
  logic           unused_bits;
  // The second decoder replays the latched memory opcode so the address mux stays stable in S_MEM.
  instr_decoder u_dec  (.opcode(INSTRUCTION[31:24]), .ctrl(dec));
  instr_decoder u_held (.opcode(op_q), .ctrl(held));
  assign unused_bits = ^{INSTRUCTION[23:0], held};
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_EXEC;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    {MUX_IM, MUX_2C, ALUOP, WRITEENABLE, MUX_MEM, READ, WRITE, JUMP, BRANCH, PC_EN, ILLEGAL} = '0;
    case (state_q)
      S_EXEC: if (!I_BUSYWAIT) begin
        MUX_IM      = dec.mux_im;
        MUX_2C      = dec.mux_2c;
        ALUOP       = dec.aluop;
        WRITEENABLE = dec.we;
        JUMP        = dec.jump;
        BRANCH      = dec.branch;
        ILLEGAL     = dec.illegal;
        PC_EN       = !dec.mem;
        if (dec.mem) begin
          op_d    = INSTRUCTION[31:24];
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        MUX_IM = held.mux_im;
        ALUOP  = held.aluop;
        READ   = held.load;
        WRITE  = held.mem && !held.load;
        if (!BUSYWAIT) begin
          PC_EN   = !held.load;
          state_d = held.load ? S_WB : S_EXEC;
        end
      end
      S_WB: begin
        WRITEENABLE = 1'b1;
        MUX_MEM     = 1'b1;
        PC_EN       = 1'b1;
        state_d     = S_EXEC;
      end
      default: state_d = S_EXEC;
    endcase
    // Outputs are gated while reset is held so an aborted access never strobes anything.
    if (!RESET)
      {MUX_IM, MUX_2C, ALUOP, WRITEENABLE, MUX_MEM, READ, WRITE, JUMP, BRANCH, PC_EN, ILLEGAL} = '0;
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer
module tb_control_sequencer;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTRUCTION = 32'h0;
  logic        I_BUSYWAIT = 1'b0;
  logic        BUSYWAIT = 1'b0;
  logic        MUX_IM, MUX_2C, WRITEENABLE, MUX_MEM, READ, WRITE, JUMP, BRANCH, PC_EN, ILLEGAL;
  logic [2:0]  ALUOP;
  logic [12:0] outv;
  int          n_vec = 0;
  int          n_bad = 0;
  string       tag_q[$];
  logic [12:0] exp_q[$];
  localparam logic [31:0] ADD_W = 32'h02000000;
  localparam logic [12:0] Z = '0;

  control_sequencer dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .I_BUSYWAIT(I_BUSYWAIT), .BUSYWAIT(BUSYWAIT),
    .MUX_IM(MUX_IM), .MUX_2C(MUX_2C), .ALUOP(ALUOP), .WRITEENABLE(WRITEENABLE), .MUX_MEM(MUX_MEM),
    .READ(READ), .WRITE(WRITE), .JUMP(JUMP), .BRANCH(BRANCH), .PC_EN(PC_EN), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;
  assign outv = {MUX_IM, MUX_2C, ALUOP, WRITEENABLE, MUX_MEM, READ, WRITE, JUMP, BRANCH, PC_EN, ILLEGAL};

  function automatic logic [12:0] ev(input logic im, c2, input logic [2:0] op,
                                     input logic we, mm, rd, wr, j, br, pc, il);
    return {im, c2, op, we, mm, rd, wr, j, br, pc, il};
  endfunction

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (im 2c aluop we mm rd wr j br pc il)", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic ib, input logic b,
                      input logic [12:0] e);
    @(posedge CLK);
    #1;
    INSTRUCTION = ins;
    I_BUSYWAIT  = ib;
    BUSYWAIT    = b;
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  always @(negedge CLK)
    if (exp_q.size() > 0) chk(tag_q.pop_front(), outv, exp_q.pop_front());

  initial begin
    INSTRUCTION = 32'h03010203;
    #3 chk("reset_gated", outv, Z);
    @(posedge CLK);
    #1 RESET = 1'b1;
    // single-cycle ALU ops
    step("sub",   32'h03010203, 0, 0, ev(1,1,3'b001,1,0,0,0,0,0,1,0));
    step("loadi", 32'h0004002A, 0, 0, ev(0,0,3'b000,1,0,0,0,0,0,1,0));
    step("mov",   32'h01020300, 0, 0, ev(1,0,3'b000,1,0,0,0,0,0,1,0));
    step("add",   ADD_W,        0, 0, ev(1,0,3'b001,1,0,0,0,0,0,1,0));
    step("and",   32'h04010203, 0, 0, ev(1,0,3'b010,1,0,0,0,0,0,1,0));
    step("or",    32'h05010203, 0, 0, ev(1,0,3'b011,1,0,0,0,0,0,1,0));
    step("j",     32'h06000010, 0, 0, ev(0,0,3'b000,0,0,0,0,1,0,1,0));
    step("beq",   32'h07000102, 0, 0, ev(1,1,3'b001,0,0,0,0,0,1,1,0));
    // lwd with four stall cycles
    step("lwd_c1", 32'h08010002, 0, 1, ev(1,0,3'b000,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      step($sformatf("lwd_stall%0d", i), ADD_W, i[0], 1, ev(1,0,3'b000,0,0,1,0,0,0,0,0));
    step("lwd_c6", ADD_W, 0, 0, ev(1,0,3'b000,0,0,1,0,0,0,0,0));
    step("lwd_wb", ADD_W, 0, 0, ev(0,0,3'b000,1,1,0,0,0,0,1,0));
    step("after_lwd", ADD_W, 0, 0, ev(1,0,3'b001,1,0,0,0,0,0,1,0));
    // swi cache hit
    step("swi_c1", 32'h0B000540, 0, 0, Z);
    step("swi_c2", ADD_W, 0, 0, ev(0,0,3'b000,0,0,0,1,0,0,1,0));
    step("swi_c3", ADD_W, 0, 0, ev(1,0,3'b001,1,0,0,0,0,0,1,0));
    // swd with one stall
    step("swd_c1", 32'h0A000102, 0, 1, ev(1,0,3'b000,0,0,0,0,0,0,0,0));
    step("swd_c2", ADD_W, 0, 1, ev(1,0,3'b000,0,0,0,1,0,0,0,0));
    step("swd_c3", ADD_W, 0, 0, ev(1,0,3'b000,0,0,0,1,0,0,1,0));
    // lwd cache hit: three-cycle minimum
    step("lwdh_c1", 32'h08010002, 0, 0, ev(1,0,3'b000,0,0,0,0,0,0,0,0));
    step("lwdh_c2", ADD_W, 0, 0, ev(1,0,3'b000,0,0,1,0,0,0,0,0));
    step("lwdh_wb", ADD_W, 0, 0, ev(0,0,3'b000,1,1,0,0,0,0,1,0));
    // lwi aborted by reset in S_MEM
    step("lwi_c1", 32'h09000020, 0, 1, Z);
    step("lwi_c2", ADD_W, 0, 1, ev(0,0,3'b000,0,0,1,0,0,0,0,0));
    #6;
    I_BUSYWAIT = 1'b1;
    RESET = 1'b0;
    #1 chk("lwi_rst_async", outv, Z);
    BUSYWAIT = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b1;
    #1 chk("lwi_rel_bubble", outv, Z);
    step("lwi_after_rst", ADD_W, 0, 0, ev(1,0,3'b001,1,0,0,0,0,0,1,0));
    // illegal opcode and fetch bubbles
    step("illegal", 32'hFF000000, 0, 0, ev(0,0,3'b000,0,0,0,0,0,0,1,1));
    step("illegal_end", ADD_W, 0, 0, ev(1,0,3'b001,1,0,0,0,0,0,1,0));
    step("ibusy_add", ADD_W, 1, 0, Z);
    step("ibusy_swi", 32'h0B000540, 1, 0, Z);
    step("ibusy_ill", 32'hFF000000, 1, 1, Z);
    step("after_bubble", 32'h0004002A, 0, 0, ev(0,0,3'b000,1,0,0,0,0,0,1,0));
    @(posedge CLK);
    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control unit for the 8-bit CPU datapath.
- Decodes the 32-bit instruction word and drives the operand-mux selects: immediate-vs-register (MUX_IM) and two's-complement (MUX_2C). Also drives ALU op, register-file write enable and branch/jump controls.
- Sequences load/store through the data cache: issues READ/WRITE, stalls the PC while BUSYWAIT is high, then performs the load writeback.
- Sits between instruction memory/PC and the register file / ALU / data cache.

Parameters:
- OPW, 8, opcode field width (INSTRUCTION[31:24]).
- ALUOPW, 3, ALU select width.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- INSTRUCTION  input  32  fetched word; opcode = [31:24].
- I_BUSYWAIT  input  1  instruction cache stall; INSTRUCTION is invalid while high.
- BUSYWAIT  input  1  data cache stall.
- MUX_IM  output  1  0 = immediate operand, 1 = register/complement path.
- MUX_2C  output  1  1 = negated SRC2 (sub, beq), 0 = SRC2 as-is.
- ALUOP  output  3  000 fwd, 001 add, 010 and, 011 or.
- WRITEENABLE  output  1  register-file write strobe.
- MUX_MEM  output  1  1 = writeback data from cache READDATA, 0 = ALU result.
- READ  output  1  data cache read request.
- WRITE  output  1  data cache write request.
- JUMP  output  1  unconditional PC target select.
- BRANCH  output  1  conditional PC target select; taken when ALU ZERO (ZERO gating is external).
- PC_EN  output  1  PC update enable.
- ILLEGAL  output  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Opcodes:
  - 0x00 loadi, 0x01 mov, 0x02 add, 0x03 sub, 0x04 and, 0x05 or, 0x06 j, 0x07 beq.
  - 0x08 lwd, 0x09 lwi, 0x0A swd, 0x0B swi.
  - 0x0C–0xFF are illegal.
- State is registered. States: S_EXEC, S_MEM, S_WB.
- Reset (RESET low, async):
  - state = S_EXEC, OP_Q = 0x00.
  - Every output is forced to 0 (gated), including PC_EN, while RESET is low.
- S_EXEC, I_BUSYWAIT = 1: bubble. All enables 0, PC_EN = 0, state holds.
- S_EXEC, I_BUSYWAIT = 0: combinational decode of INSTRUCTION; PC_EN = 1 except for memory ops.
  - loadi: MUX_IM=0, ALUOP=000, WRITEENABLE=1.
  - mov: MUX_IM=1, MUX_2C=0, ALUOP=000, WRITEENABLE=1.
  - add/and/or: MUX_IM=1, MUX_2C=0, ALUOP=001/010/011, WRITEENABLE=1.
  - sub: MUX_IM=1, MUX_2C=1, ALUOP=001, WRITEENABLE=1.
  - j: JUMP=1, WRITEENABLE=0.
  - beq: MUX_IM=1, MUX_2C=1, ALUOP=001, BRANCH=1, WRITEENABLE=0.
  - lwd/lwi/swd/swi:
    - MUX_IM=1 for lwd/swd, 0 for lwi/swi; ALUOP=000.
    - PC_EN=0; latch opcode into OP_Q; next state S_MEM.
  - illegal: ILLEGAL=1, treated as a nop (PC_EN=1, no writes).
- S_MEM:
  - READ = 1 (lwd/lwi) or WRITE = 1 (swd/swi), derived from OP_Q and held continuously.
  - MUX_IM is held from OP_Q so the address stays stable.
  - PC_EN = 0.
  - BUSYWAIT = 1: stay in S_MEM.
  - BUSYWAIT = 0, load: go to S_WB. BUSYWAIT = 0, store: PC_EN = 1, go to S_EXEC.
  - A single-cycle BUSYWAIT=0 on the first S_MEM cycle (cache hit) is legal: minimum store latency is 2 cycles.
- S_WB (loads only, exactly 1 cycle):
  - WRITEENABLE=1, MUX_MEM=1, READ=0, PC_EN=1.
  - Next state S_EXEC.
  - Minimum load latency is 3 cycles.
- READ and WRITE are never both high. READ/WRITE drop in the cycle after BUSYWAIT falls.
- A RESET assertion mid-S_MEM or mid-S_WB aborts immediately: outputs go to 0 and no writeback occurs.
- Undefined state encodings recover to S_EXEC.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (OP_LOADI..OP_SWI).
  - ALUOP encodings.
  - state enum S_EXEC/S_MEM/S_WB.
- One natural sub-module, instr_decoder: purely combinational, opcode to control-bundle. Used for S_EXEC decode, and on OP_Q for S_MEM hold values.
- The FSM and output gating stay in control_sequencer.

Test Plan:
- sub 0x03_01_02_03, I_BUSYWAIT=0 -> same cycle: MUX_IM=1, MUX_2C=1, ALUOP=001, WRITEENABLE=1, PC_EN=1; state remains S_EXEC.
- loadi 0x00_04_00_2A -> MUX_IM=0, ALUOP=000, WRITEENABLE=1, READ=0, WRITE=0.
- lwd 0x08_01_00_02, BUSYWAIT held high for 4 cycles then low -> PC_EN=0 for 6 cycles, then S_WB with WRITEENABLE=1, MUX_MEM=1, PC_EN=1.
  - READ high from cycle 2 through cycle 6, low in S_WB.
- swi 0x0B_00_05_40, BUSYWAIT low on first S_MEM cycle -> WRITE=1 for 1 cycle; PC_EN=1 in that cycle; no WRITEENABLE at any point; back in S_EXEC on cycle 3.
- lwi with RESET pulled low during S_MEM -> all outputs 0 asynchronously; after release, state S_EXEC, no writeback pulse.
- opcode 0xFF -> ILLEGAL=1 for 1 cycle, WRITEENABLE=0, PC_EN=1. With I_BUSYWAIT=1 on any opcode -> all outputs 0.
